sys_bridge_hs: RTL and testbench

//  Parametrised, handshaked system bridge between the CPU data port and NUM_SLV

---
 rtl/sys_bridge_hs.sv | 159 +++++++++++++++
 tb/tb_sys_bridge_hs.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_bridge_hs.sv
// Handshaked CPU-to-slave bridge: decodes a request against per-slot address
// windows, holds it to the selected slave until ack or timeout, returns one response.
module sys_bridge_hs #(
    parameter int                    NUM_SLV = 4,
    parameter logic [NUM_SLV*32-1:0] SLV_LO  = {32'h0000_7F20, 32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000},
    parameter logic [NUM_SLV*32-1:0] SLV_HI  = {32'h0000_7F23, 32'h0000_7F1B, 32'h0000_7F0B, 32'h0000_2FFF},
    parameter int                    TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  m_req,
    output logic                  m_ready,
    input  logic [31:0]           m_addr,
    input  logic [31:0]           m_wdata,
    input  logic [3:0]            m_byteen,
    output logic                  m_rvalid,
    output logic [31:0]           m_rdata,
    output logic                  m_err,
    output logic [NUM_SLV-1:0]    s_sel,
    output logic [31:0]           s_addr,
    output logic [31:0]           s_wdata,
    output logic [3:0]            s_byteen,
    output logic                  s_we,
    input  logic [NUM_SLV*32-1:0] s_rdata,
    input  logic [NUM_SLV-1:0]    s_ack
);

    localparam int             CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_SLV-1:0]   s_sel_q, s_sel_d;
    logic [31:0]          s_addr_q, s_addr_d;
    logic [31:0]          s_wdata_q, s_wdata_d;
    logic [3:0]           s_byteen_q, s_byteen_d;
    logic [31:0]          m_rdata_q, m_rdata_d;
    logic                 m_err_q, m_err_d;

    logic [NUM_SLV-1:0]   hit_onehot;
    logic                 hit_any;
    logic [31:0]          sel_rdata;
    logic                 ack_hit;

    // Walk slots from highest to lowest so the lowest matching slot is the last writer.
    always_comb begin
        hit_onehot = '0;
        for (int k = NUM_SLV - 1; k >= 0; k--) begin
            if (m_addr >= SLV_LO[k*32 +: 32] && m_addr <= SLV_HI[k*32 +: 32]) begin
                hit_onehot    = '0;
                hit_onehot[k] = 1'b1;
            end
        end
        hit_any = |hit_onehot;
    end

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (s_sel_q[k]) begin
                sel_rdata = s_rdata[k*32 +: 32];
            end
        end
        ack_hit = |(s_ack & s_sel_q);
    end

    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        cnt_d      = cnt_q;
        s_sel_d    = s_sel_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_byteen_d = s_byteen_q;
        m_rdata_d  = m_rdata_q;
        m_err_d    = m_err_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (m_req) begin
                    s_addr_d   = m_addr;
                    s_wdata_d  = m_wdata;
                    s_byteen_d = m_byteen;
                    if (hit_any) begin
                        s_sel_d = hit_onehot;
                        state_d = ST_ACCESS;
                    end else begin
                        m_rdata_d = '0;
                        m_err_d   = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // The ack is tested first so it beats a timeout landing in the same cycle.
                if (ack_hit) begin
                    m_rdata_d = (|s_byteen_q) ? 32'h0 : sel_rdata;
                    m_err_d   = 1'b0;
                    s_sel_d   = '0;
                    state_d   = ST_RESP;
                end else if (cnt_d == TO_VAL) begin
                    m_rdata_d = '0;
                    m_err_d   = 1'b1;
                    s_sel_d   = '0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            s_sel_q    <= '0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_byteen_q <= '0;
            m_rdata_q  <= '0;
            m_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s_sel_q    <= s_sel_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_byteen_q <= s_byteen_d;
            m_rdata_q  <= m_rdata_d;
            m_err_q    <= m_err_d;
        end
    end

    assign m_ready  = (state_q == ST_IDLE);
    assign m_rvalid = (state_q == ST_RESP);
    assign m_rdata  = m_rdata_q;
    assign m_err    = m_err_q;
    assign s_sel    = s_sel_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_byteen = s_byteen_q;
    assign s_we     = (|s_byteen_q) & (|s_sel_q);

endmodule

// File: tb/tb_sys_bridge_hs.sv
// Self-checking bench for sys_bridge_hs: expected responses are queued when a
// request is issued and compared when the bridge strobes m_rvalid.
module tb_sys_bridge_hs;

    localparam int NUM_SLV = 4;

    logic                  clk;
    logic                  reset_n;
    logic                  m_req;
    logic                  m_ready;
    logic [31:0]           m_addr;
    logic [31:0]           m_wdata;
    logic [3:0]            m_byteen;
    logic                  m_rvalid;
    logic [31:0]           m_rdata;
    logic                  m_err;
    logic [NUM_SLV-1:0]    s_sel;
    logic [31:0]           s_addr;
    logic [31:0]           s_wdata;
    logic [3:0]            s_byteen;
    logic                  s_we;
    logic [NUM_SLV*32-1:0] s_rdata;
    logic [NUM_SLV-1:0]    s_ack;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb[$];
    resp_t exp_r;
    int    n_pass;
    int    n_total;

    sys_bridge_hs dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m_req    (m_req),
        .m_ready  (m_ready),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_byteen (m_byteen),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .m_err    (m_err),
        .s_sel    (s_sel),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_byteen (s_byteen),
        .s_we     (s_we),
        .s_rdata  (s_rdata),
        .s_ack    (s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller sits at a negedge with the bridge idle; request is accepted at the next posedge.
    task automatic issue(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
        m_req    = 1'b1;
        m_addr   = a;
        m_wdata  = w;
        m_byteen = be;
        @(negedge clk);
        m_req    = 1'b0;
    endtask

    task automatic pop_exp(output resp_t r, output bit ok);
        ok = (sb.size() != 0);
        r  = '0;
        if (ok) r = sb.pop_front();
    endtask

    task automatic test_reset();
        bit ok;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        ok = (m_ready === 1'b1 && m_rvalid === 1'b0 && m_rdata === 32'h0 && m_err === 1'b0 &&
              s_sel === 4'b0 && s_addr === 32'h0 && s_wdata === 32'h0 && s_byteen === 4'h0 && s_we === 1'b0);
        if (!ok) $display("FAIL reset_state: ready=%b rvalid=%b rdata=%h err=%b sel=%b addr=%h we=%b, required ready=1 others 0",
                          m_ready, m_rvalid, m_rdata, m_err, s_sel, s_addr, s_we);
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_zero_wait();
        bit ok;
        sb.push_back('{rdata: 32'h1234_5678, err: 1'b0});
        issue(32'h0000_1004, 32'h0, 4'b0000);
        n_total++;
        if (s_sel !== 4'b0001 || s_we !== 1'b0 || s_addr !== 32'h0000_1004)
            $display("FAIL rd_sel: sel=%b we=%b addr=%h, required 0001 0 00001004", s_sel, s_we, s_addr);
        else n_pass++;
        s_ack = 4'b0001;
        @(negedge clk);
        s_ack = 4'b0000;
        n_total++;
        if (m_rvalid !== 1'b1 || s_sel !== 4'b0)
            $display("FAIL rd_latency: rvalid=%b sel=%b, required rvalid=1 sel=0000", m_rvalid, s_sel);
        else n_pass++;
        pop_exp(exp_r, ok);
        n_total++;
        if (!ok || m_rdata !== exp_r.rdata || m_err !== exp_r.err)
            $display("FAIL rd_resp: rdata=%h err=%b, required %h %b", m_rdata, m_err, exp_r.rdata, exp_r.err);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (m_rvalid !== 1'b0 || m_ready !== 1'b1)
            $display("FAIL rd_one_strobe: rvalid=%b ready=%b, required 0 1", m_rvalid, m_ready);
        else n_pass++;
    endtask

    task automatic test_unmapped();
        bit ok;
        sb.push_back('{rdata: 32'h0, err: 1'b1});
        issue(32'h0000_5000, 32'h0, 4'b0000);
        n_total++;
        if (m_rvalid !== 1'b1 || s_sel !== 4'b0)
            $display("FAIL unmapped_latency: rvalid=%b sel=%b, required 1 0000", m_rvalid, s_sel);
        else n_pass++;
        pop_exp(exp_r, ok);
        n_total++;
        if (!ok || m_rdata !== exp_r.rdata || m_err !== exp_r.err)
            $display("FAIL unmapped_resp: rdata=%h err=%b, required %h %b", m_rdata, m_err, exp_r.rdata, exp_r.err);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_write_wait();
        bit ok;
        int sel_cycles;
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        issue(32'h0000_7F04, 32'hA5A5_0001, 4'b1111);
        n_total++;
        if (s_wdata !== 32'hA5A5_0001 || s_byteen !== 4'b1111)
            $display("FAIL wr_latch: wdata=%h byteen=%b, required a5a50001 1111", s_wdata, s_byteen);
        else n_pass++;
        sel_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (s_sel === 4'b0010 && s_we === 1'b1) sel_cycles++;
            s_ack = (i == 3) ? 4'b0010 : 4'b0000;
            @(negedge clk);
        end
        s_ack = 4'b0000;
        n_total++;
        if (sel_cycles != 4 || s_sel !== 4'b0 || s_we !== 1'b0)
            $display("FAIL wr_sel_cycles: cycles=%0d sel=%b we=%b, required 4 0000 0", sel_cycles, s_sel, s_we);
        else n_pass++;
        pop_exp(exp_r, ok);
        n_total++;
        if (!ok || m_rvalid !== 1'b1 || m_rdata !== exp_r.rdata || m_err !== exp_r.err)
            $display("FAIL wr_resp: rvalid=%b rdata=%h err=%b, required 1 %h %b", m_rvalid, m_rdata, m_err, exp_r.rdata, exp_r.err);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_ack_vs_timeout();
        bit ok;
        int sel_cycles;
        sb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
        issue(32'h0000_7F10, 32'h0, 4'b0000);
        sel_cycles = 0;
        for (int i = 0; i < 15; i++) begin
            if (s_sel === 4'b0100) sel_cycles++;
            s_ack = (i == 2) ? 4'b0001 : (i == 14) ? 4'b0100 : 4'b0000;
            @(negedge clk);
        end
        s_ack = 4'b0000;
        n_total++;
        if (sel_cycles != 15)
            $display("FAIL stray_ack_ignored: sel cycles=%0d, required 15", sel_cycles);
        else n_pass++;
        pop_exp(exp_r, ok);
        n_total++;
        if (!ok || m_rvalid !== 1'b1 || m_rdata !== exp_r.rdata || m_err !== exp_r.err)
            $display("FAIL ack_wins: rvalid=%b rdata=%h err=%b, required 1 %h %b", m_rvalid, m_rdata, m_err, exp_r.rdata, exp_r.err);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok;
        bit seen;
        int sel_cycles;
        sb.push_back('{rdata: 32'h0, err: 1'b1});
        issue(32'h0000_7F20, 32'h0, 4'b0000);
        sel_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 25 && !seen; i++) begin
            if (m_rvalid === 1'b1) seen = 1'b1;
            else begin
                if (s_sel === 4'b1000) sel_cycles++;
                @(negedge clk);
            end
        end
        n_total++;
        if (!seen || sel_cycles != 15)
            $display("FAIL timeout_cycles: seen=%b sel cycles=%0d, required 1 15", seen, sel_cycles);
        else n_pass++;
        pop_exp(exp_r, ok);
        n_total++;
        if (!ok || m_rdata !== exp_r.rdata || m_err !== exp_r.err)
            $display("FAIL timeout_resp: rdata=%h err=%b, required %h %b", m_rdata, m_err, exp_r.rdata, exp_r.err);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        bit ok;
        issue(32'h0000_0100, 32'h0, 4'b0000);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if (s_sel !== 4'b0 || m_rvalid !== 1'b0 || m_ready !== 1'b1)
            $display("FAIL reset_mid_access: sel=%b rvalid=%b ready=%b, required 0000 0 1", s_sel, m_rvalid, m_ready);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        sb.push_back('{rdata: 32'h1111_0000, err: 1'b0});
        issue(32'h0000_2FFF, 32'h0, 4'b0000);
        n_total++;
        if (s_sel !== 4'b0001)
            $display("FAIL after_reset_sel: sel=%b, required 0001", s_sel);
        else n_pass++;
        s_ack = 4'b0001;
        @(negedge clk);
        s_ack = 4'b0000;
        pop_exp(exp_r, ok);
        n_total++;
        if (!ok || m_rvalid !== 1'b1 || m_rdata !== exp_r.rdata || m_err !== exp_r.err)
            $display("FAIL after_reset_resp: rvalid=%b rdata=%h err=%b, required 1 %h %b", m_rvalid, m_rdata, m_err, exp_r.rdata, exp_r.err);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        sb.push_back('{rdata: 32'h0, err: 1'b1});
        sb.push_back('{rdata: 32'h2222_0001, err: 1'b0});
        issue(32'h0000_7F0C, 32'h0, 4'b0000);
        m_req  = 1'b1;
        m_addr = 32'h0000_7F0B;
        pop_exp(exp_r, ok);
        n_total++;
        if (!ok || m_rvalid !== 1'b1 || m_ready !== 1'b0 || m_err !== exp_r.err || m_rdata !== exp_r.rdata)
            $display("FAIL b2b_first: rvalid=%b ready=%b err=%b rdata=%h, required 1 0 %b %h", m_rvalid, m_ready, m_err, m_rdata, exp_r.err, exp_r.rdata);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (m_ready !== 1'b1 || s_sel !== 4'b0 || m_rvalid !== 1'b0)
            $display("FAIL b2b_held_req: ready=%b sel=%b rvalid=%b, required 1 0000 0", m_ready, s_sel, m_rvalid);
        else n_pass++;
        @(negedge clk);
        m_req = 1'b0;
        n_total++;
        if (s_sel !== 4'b0010)
            $display("FAIL b2b_second_sel: sel=%b, required 0010", s_sel);
        else n_pass++;
        s_ack = 4'b0010;
        @(negedge clk);
        s_ack = 4'b0000;
        pop_exp(exp_r, ok);
        n_total++;
        if (!ok || m_rvalid !== 1'b1 || m_rdata !== exp_r.rdata || m_err !== exp_r.err)
            $display("FAIL b2b_second_resp: rvalid=%b rdata=%h err=%b, required 1 %h %b", m_rvalid, m_rdata, m_err, exp_r.rdata, exp_r.err);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (sb.size() != 0)
            $display("FAIL sb_drained: %0d entries left, required 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        reset_n  = 1'b0;
        m_req    = 1'b0;
        m_addr   = 32'h0;
        m_wdata  = 32'h0;
        m_byteen = 4'h0;
        s_ack    = 4'h0;
        s_rdata  = {32'hCAFE_F00D, 32'h0000_DEAD, 32'h2222_0001, 32'h1234_5678};

        test_reset();
        test_read_zero_wait();
        test_unmapped();
        test_write_wait();
        s_rdata = {32'h3333_0003, 32'hCAFE_F00D, 32'h2222_0001, 32'h1234_5678};
        test_ack_vs_timeout();
        test_timeout();
        s_rdata[31:0] = 32'h1111_0000;
        test_reset_mid_access();
        test_back_to_back();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
